// File: rtl/niosii_processor_nios_cpu_debug_host.sv
// Host end of the Nios II debug-slave virtual JTAG link.
// Runs UIR -> CDR -> SDR(38) -> UDR per command, returns captured DR.
//
// Ports:
//   clk, reset           system clock, async active-high reset
//   cmd_valid/cmd_ready  command handshake (cmd_ir, cmd_data)
//   rsp_valid/rsp_ready  response handshake (rsp_data)
//   tck, tdi, tdo        generated JTAG clock and serial data
//   ir_in, vs_*          virtual IR and virtual state strobes
//   jtag_state_rti       slave in run-test-idle
module niosii_processor_nios_cpu_debug_host #(
   parameter int unsigned TCK_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_ir,
   input  logic [37:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [37:0] rsp_data,
   output logic        tck,
   output logic        tdi,
   input  logic        tdo,
   output logic [1:0]  ir_in,
   output logic        vs_uir,
   output logic        vs_cdr,
   output logic        vs_sdr,
   output logic        vs_udr,
   output logic        jtag_state_rti
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UIR,
      S_CDR,
      S_SDR,
      S_UDR,
      S_RESP
   } state_t;

   localparam logic [8:0] PH_LAST = 9'(2 * TCK_DIV - 1);
   localparam logic [8:0] PH_HI   = 9'(TCK_DIV);

   state_t      state_q, state_d;
   logic [8:0]  ph_q, ph_d;
   logic [5:0]  bit_q, bit_d;
   logic [37:0] dat_q, dat_d;
   logic [37:0] cap_q, cap_d;
   logic [1:0]  ir_q, ir_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [37:0] rsp_data_q, rsp_data_d;
   logic        tck_q, tck_d;
   logic        tdi_q, tdi_d;
   logic        uir_q, uir_d;
   logic        cdr_q, cdr_d;
   logic        sdr_q, sdr_d;
   logic        udr_q, udr_d;
   logic        rdy_q, rdy_d;
   logic        rti_q, rti_d;

   logic        ph_last;
   logic [8:0]  ph_nx;
   logic        tck_nx;
   logic        rise;

   // Phase counter spans one TCK period; tck is high in its upper half.
   assign ph_last = (ph_q == PH_LAST);
   assign ph_nx   = ph_last ? 9'd0 : ph_q + 9'd1;
   assign tck_nx  = (ph_nx >= PH_HI);
   // The edge on which tck goes 0->1 is where tdo is sampled.
   assign rise    = ((ph_q + 9'd1) == PH_HI);

   always_comb begin
      state_d     = state_q;
      ph_d        = ph_q;
      bit_d       = bit_q;
      dat_d       = dat_q;
      cap_d       = cap_q;
      ir_d        = ir_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      tck_d       = 1'b0;
      tdi_d       = 1'b0;
      uir_d       = 1'b0;
      cdr_d       = 1'b0;
      sdr_d       = 1'b0;
      udr_d       = 1'b0;
      rdy_d       = 1'b0;
      rti_d       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && rdy_q) begin
               state_d = S_UIR;
               ph_d    = 9'd0;
               ir_d    = cmd_ir;
               dat_d   = cmd_data;
               uir_d   = 1'b1;
            end else begin
               rdy_d = 1'b1;
               rti_d = 1'b1;
            end
         end
         S_UIR: begin
            ph_d  = ph_nx;
            tck_d = tck_nx;
            uir_d = 1'b1;
            if (ph_last) begin
               state_d = S_CDR;
               uir_d   = 1'b0;
               cdr_d   = 1'b1;
            end
         end
         S_CDR: begin
            ph_d  = ph_nx;
            tck_d = tck_nx;
            cdr_d = 1'b1;
            if (ph_last) begin
               state_d = S_SDR;
               cdr_d   = 1'b0;
               sdr_d   = 1'b1;
               bit_d   = 6'd0;
               tdi_d   = dat_q[0];
            end
         end
         S_SDR: begin
            ph_d  = ph_nx;
            tck_d = tck_nx;
            sdr_d = 1'b1;
            tdi_d = tdi_q;
            if (rise) begin
               cap_d = {tdo, cap_q[37:1]};
            end
            if (ph_last) begin
               if (bit_q == 6'd37) begin
                  state_d = S_UDR;
                  sdr_d   = 1'b0;
                  udr_d   = 1'b1;
                  tdi_d   = 1'b0;
                  bit_d   = 6'd0;
               end else begin
                  // Next bit is presented at the start of its period.
                  bit_d = bit_q + 6'd1;
                  dat_d = {1'b0, dat_q[37:1]};
                  tdi_d = dat_q[1];
               end
            end
         end
         S_UDR: begin
            ph_d  = ph_nx;
            tck_d = tck_nx;
            udr_d = 1'b1;
            if (ph_last) begin
               state_d = S_RESP;
               udr_d   = 1'b0;
            end
         end
         S_RESP: begin
            // First RESP cycle loads the response register.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = cap_q;
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
               rdy_d       = 1'b1;
               rti_d       = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ph_q        <= 9'd0;
         bit_q       <= 6'd0;
         dat_q       <= 38'd0;
         cap_q       <= 38'd0;
         ir_q        <= 2'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 38'd0;
         tck_q       <= 1'b0;
         tdi_q       <= 1'b0;
         uir_q       <= 1'b0;
         cdr_q       <= 1'b0;
         sdr_q       <= 1'b0;
         udr_q       <= 1'b0;
         rdy_q       <= 1'b0;
         rti_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         bit_q       <= bit_d;
         dat_q       <= dat_d;
         cap_q       <= cap_d;
         ir_q        <= ir_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         tck_q       <= tck_d;
         tdi_q       <= tdi_d;
         uir_q       <= uir_d;
         cdr_q       <= cdr_d;
         sdr_q       <= sdr_d;
         udr_q       <= udr_d;
         rdy_q       <= rdy_d;
         rti_q       <= rti_d;
      end
   end

   assign cmd_ready      = rdy_q;
   assign jtag_state_rti = rti_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign tck            = tck_q;
   assign tdi            = tdi_q;
   assign ir_in          = ir_q;
   assign vs_uir         = uir_q;
   assign vs_cdr         = cdr_q;
   assign vs_sdr         = sdr_q;
   assign vs_udr         = udr_q;

endmodule

// File: tb/tb_niosii_processor_nios_cpu_debug_host.sv
// Bench for the virtual JTAG debug host: timeline model plus a
// 38-bit slave DR model on each of two instances (TCK_DIV 3 and 1).
module tb_niosii_processor_nios_cpu_debug_host;

   localparam int D    = 3;
   localparam int BUSY = 82 * D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   // ---------------- main DUT (TCK_DIV = 3) ----------------
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [1:0]  cmd_ir = 2'b0;
   logic [37:0] cmd_data = 38'd0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [37:0] rsp_data;
   logic        tck, tdi, tdo;
   logic [1:0]  ir_in;
   logic        vs_uir, vs_cdr, vs_sdr, vs_udr, rti;

   niosii_processor_nios_cpu_debug_host #(.TCK_DIV(D)) u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
      .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
      .vs_udr(vs_udr), .jtag_state_rti(rti));

   // Slave DR model: shifts on tck rise while in SDR, tdo = DR[0].
   logic [37:0] sdr = 38'd0, pre_val = 38'd0, udr_dr = 38'd0;
   logic [1:0]  udr_ir = 2'd0;
   logic        pre_en = 1'b0, cnt_clr = 1'b0;
   logic        tck_p = 1'b0, udr_p = 1'b0;
   int          tck_rises = 0, sdr_rises = 0;
   assign tdo = sdr[0];

   always @(posedge clk) begin
      tck_p <= tck;
      udr_p <= vs_udr;
      if (pre_en) sdr <= pre_val;
      else if (tck && !tck_p && vs_sdr) sdr <= {tdi, sdr[37:1]};
      if (cnt_clr) begin
         tck_rises <= 0;
         sdr_rises <= 0;
      end else if (tck && !tck_p) begin
         tck_rises <= tck_rises + 1;
         if (vs_sdr) sdr_rises <= sdr_rises + 1;
      end
      if (vs_udr && !udr_p) begin
         udr_dr <= sdr;
         udr_ir <= ir_in;
      end
   end

   // ---------------- second DUT (TCK_DIV = 1) ----------------
   logic        cmd_valid1 = 1'b0, cmd_ready1;
   logic [1:0]  cmd_ir1 = 2'b0;
   logic [37:0] cmd_data1 = 38'd0;
   logic        rsp_valid1, rsp_ready1 = 1'b0;
   logic [37:0] rsp_data1;
   logic        tck1, tdi1, tdo1;
   logic [1:0]  ir_in1;
   logic        vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1;

   niosii_processor_nios_cpu_debug_host #(.TCK_DIV(1)) u_d1 (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_ir(cmd_ir1), .cmd_data(cmd_data1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_data(rsp_data1),
      .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir_in1),
      .vs_uir(vs_uir1), .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1),
      .vs_udr(vs_udr1), .jtag_state_rti(rti1));

   logic [37:0] sdr1 = 38'd0, pre_val1 = 38'd0, udr_dr1 = 38'd0;
   logic [1:0]  udr_ir1 = 2'd0;
   logic        pre_en1 = 1'b0, tck_p1 = 1'b0, udr_p1 = 1'b0;
   assign tdo1 = sdr1[0];

   always @(posedge clk) begin
      tck_p1 <= tck1;
      udr_p1 <= vs_udr1;
      if (pre_en1) sdr1 <= pre_val1;
      else if (tck1 && !tck_p1 && vs_sdr1) sdr1 <= {tdi1, sdr1[37:1]};
      if (vs_udr1 && !udr_p1) begin
         udr_dr1 <= sdr1;
         udr_ir1 <= ir_in1;
      end
   end

   // ---------------- timeline model + compare (main DUT) ----------------
   localparam int M_POST = 0, M_IDLE = 1, M_BUSY = 2;
   int          mode = M_POST;
   int          n = 0, p, ph;
   logic [37:0] m_data, m_rsp;
   logic [1:0]  m_ir, last_ir = 2'b0;
   logic [10:0] act, e;
   logic        e_tdi, in_sdr;

   always @(negedge clk) begin
      act = {cmd_ready, rti, rsp_valid, tck, tdi,
             vs_uir, vs_cdr, vs_sdr, vs_udr, ir_in};
      if (reset) begin
         chk("reset_outputs", act, 11'd0);
         chk("reset_rsp_data", rsp_data, 38'd0);
         mode    = M_POST;
         last_ir = 2'b0;
      end else if (mode == M_POST) begin
         chk("post_reset_outputs", act, 11'd0);
         mode = M_IDLE;
      end else if (mode == M_IDLE) begin
         chk("idle_outputs", act, {2'b11, 7'b0, last_ir});
         if (cmd_valid) begin
            m_data = cmd_data;
            m_ir   = cmd_ir;
            m_rsp  = sdr;
            n      = 0;
            mode   = M_BUSY;
         end
      end else begin
         if (n < BUSY) begin
            p      = n / (2 * D);
            ph     = n % (2 * D);
            in_sdr = (p >= 2) && (p <= 39);
            e_tdi  = 1'b0;
            if (in_sdr) e_tdi = m_data[p - 2];
            e = {3'b000, ph >= D, e_tdi, p == 0, p == 1, in_sdr,
                 p == 40, m_ir};
            chk("busy_outputs", act, e);
         end else if (n == BUSY) begin
            chk("resp_entry_outputs", act, {9'b0, m_ir});
         end else begin
            chk("resp_outputs", act, {2'b00, 1'b1, 6'b0, m_ir});
            chk("resp_data", rsp_data, m_rsp);
            if (rsp_ready) begin
               mode    = M_IDLE;
               last_ir = m_ir;
            end
         end
         n++;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic preload(input logic [37:0] v);
      pre_val = v;
      pre_en  = 1'b1;
      @(posedge clk); #1;
      pre_en  = 1'b0;
   endtask

   task automatic clr_cnt();
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rsp_timeout", rsp_valid, 1'b1);
   endtask

   task automatic accept(input logic [1:0] ir, input logic [37:0] d);
      int w;
      cmd_ir    = ir;
      cmd_data  = d;
      cmd_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("accept_timeout", cmd_ready, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic run_cmd(input logic [1:0] ir, input logic [37:0] d,
                          input int hold, output logic [37:0] r,
                          output int lat);
      accept(ir, d);
      cmd_valid = 1'b0;
      wait_rsp(lat);
      r = rsp_data;
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         chk("hold_rsp_data", rsp_data, r);
         chk("hold_state", {rsp_valid, tck, cmd_ready}, 3'b100);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   logic [37:0] r;
   int          lat;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_rti", {cmd_ready, rti, cmd_ready1}, 3'b000);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("first_edge_ready_rti", {cmd_ready, rti}, 2'b11);

      // TCK_DIV=1 instance: literal latency and data
      pre_val1 = 38'h2A_5A5A_5A5A;
      pre_en1  = 1'b1;
      @(posedge clk); #1;
      pre_en1    = 1'b0;
      cmd_ir1    = 2'b01;
      cmd_data1  = 38'h15_A5A5_A5A5;
      cmd_valid1 = 1'b1;
      @(negedge clk);
      chk("d1_ready", cmd_ready1, 1'b1);
      @(posedge clk); #1;
      cmd_valid1 = 1'b0;
      lat = 0;
      while (!rsp_valid1 && lat < 500) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("d1_latency", lat, 83);
      chk("d1_rsp_data", rsp_data1, 38'h2A_5A5A_5A5A);
      chk("d1_udr_ir", udr_ir1, 2'b01);
      chk("d1_udr_dr", udr_dr1, 38'h15_A5A5_A5A5);
      rsp_ready1 = 1'b1;
      @(posedge clk); #1;
      rsp_ready1 = 1'b0;
      chk("d1_back_idle", {cmd_ready1, rti1, rsp_valid1}, 3'b110);

      // TCK_DIV=3 instance: full transaction with held response
      preload(38'h2A_5A5A_5A5A);
      clr_cnt();
      run_cmd(2'b01, 38'h15_A5A5_A5A5, 20, r, lat);
      chk("latency", lat, 247);
      chk("rsp_literal", r, 38'h2A_5A5A_5A5A);
      chk("tck_rises", tck_rises, 41);
      chk("sdr_rises", sdr_rises, 38);
      chk("udr_ir", udr_ir, 2'b01);
      chk("udr_dr", udr_dr, 38'h15_A5A5_A5A5);

      // Loopback through the slave DR
      run_cmd(2'b10, {38{1'b1}}, 0, r, lat);
      chk("loop_prev", r, 38'h15_A5A5_A5A5);
      run_cmd(2'b11, 38'd0, 0, r, lat);
      chk("loop_ones", r, {38{1'b1}});

      // Back-to-back with cmd_valid held; mid-flight changes ignored
      accept(2'b10, 38'h12_3456_789A);
      cmd_ir   = 2'b01;
      cmd_data = 38'h3F_0F0F_F0F0;
      wait_rsp(lat);
      chk("b2b_first_rsp", rsp_data, 38'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("b2b_idle", {cmd_ready, rti, ir_in}, {2'b11, 2'b10});
      @(posedge clk); #1;
      chk("b2b_accept", {cmd_ready, vs_uir, ir_in}, {2'b01, 2'b01});
      cmd_valid = 1'b0;
      wait_rsp(lat);
      chk("b2b_second_rsp", rsp_data, 38'h12_3456_789A);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset in the middle of SDR bit 17
      accept(2'b11, 38'h00_FFFF_0000);
      cmd_valid = 1'b0;
      repeat (19 * 2 * D + 1) @(posedge clk);
      #1;
      chk("mid_sdr", vs_sdr, 1'b1);
      reset = 1'b1;
      #1;
      chk("abort_outputs",
          {cmd_ready, rti, rsp_valid, tck, tdi, vs_uir, vs_cdr, vs_sdr,
           vs_udr, ir_in}, 11'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_rsp", {rsp_valid, cmd_ready}, 2'b01);

      // Next command after abort runs cleanly
      preload(38'h0A_BCDE_F012);
      run_cmd(2'b01, 38'h21_4365_8709, 0, r, lat);
      chk("post_abort_rsp", r, 38'h0A_BCDE_F012);
      chk("post_abort_latency", lat, 247);
      chk("post_abort_udr_dr", udr_dr, 38'h21_4365_8709);

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/niosii_processor_nios_cpu_debug_host.md
NIOSII_PROCESSOR_NIOS_CPU_DEBUG_HOST -- requirements
Module: niosii_processor_nios_cpu_debug_host

Interface
REQ-001 Parameter: TCK_DIV, default 2, clk cycles per TCK half-period; legal range 1..255.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  request to run one debug-slave transaction.
REQ-005 cmd_ready  out  1  host idle; a command is accepted on cmd_valid & cmd_ready.
REQ-006 cmd_ir  in  2  instruction to load into the slave IR.
REQ-007 cmd_data  in  38  DR value to shift into the slave.
REQ-008 rsp_valid  out  1  captured DR is valid; held until rsp_ready.
REQ-009 rsp_ready  in  1  response consumer ready.
REQ-010 rsp_data  out  38  DR value shifted out of the slave.
REQ-011 tck  out  1  generated JTAG clock to the debug slave.
REQ-012 tdi  out  1  serial data to the slave.
REQ-013 tdo  in  1  serial data from the slave.
REQ-014 ir_in  out  2  virtual IR value presented to the slave.
REQ-015 vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual state indications.
REQ-016 jtag_state_rti  out  1  slave in run-test-idle.

Function
REQ-017 The block SHALL be the host end of the debug-slave virtual JTAG link: it generates tck, tdi, ir_in and virtual states, and samples tdo.
REQ-018 States SHALL be IDLE, UIR, CDR, SDR, UDR, RESP; every output SHALL be registered.
REQ-019 One TCK period = 2*TCK_DIV clk cycles: tck low for the first TCK_DIV cycles, high for the next TCK_DIV; tck SHALL be 0 in IDLE and RESP.
REQ-020 IDLE: cmd_ready=1, jtag_state_rti=1; acceptance latches cmd_ir/cmd_data and moves to UIR on the next cycle.
REQ-021 UIR: one TCK period, vs_uir=1, ir_in=latched cmd_ir from the first UIR cycle; ir_in SHALL hold that value until the next UIR.
REQ-022 CDR: one TCK period, vs_cdr=1.
REQ-023 SDR: exactly 38 TCK periods, vs_sdr=1; 6-bit bit counter 0..37.
REQ-024 tdi SHALL carry data bit k (LSB first) during the low phase and across the rising edge of shift period k; tdi=0 outside SDR.
REQ-025 tdo SHALL be sampled in the clk cycle where tck goes 0->1 in each SDR period: cap <= {tdo, cap[37:1]}; after 38 samples cap equals the slave's original DR.
REQ-026 UDR: one TCK period, vs_udr=1, then RESP.
REQ-027 RESP: rsp_valid=1 and rsp_data=cap, held stable until rsp_valid & rsp_ready; then IDLE on the next cycle.
REQ-028 Latency: rsp_valid SHALL rise exactly 41*2*TCK_DIV + 1 clk cycles after the acceptance edge.
REQ-029 At most one vs_* SHALL be high in any cycle; all vs_* SHALL be 0 in IDLE and RESP.
REQ-030 cmd_ready SHALL be 0 in every state except IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-031 Back-to-back: cmd_valid held high during the RESP handshake SHALL be accepted one cycle after the return to IDLE.

Reset
REQ-032 While reset=1, and immediately on assertion: state=IDLE, tck=0, tdi=0, ir_in=0, all vs_*=0, cmd_ready=0, jtag_state_rti=0, rsp_valid=0, rsp_data=0, counters=0.
REQ-033 cmd_ready and jtag_state_rti SHALL become 1 on the first clk edge after reset deasserts.
REQ-034 Reset mid-transaction SHALL abort it with no response; the next command runs a complete sequence.

Verification
REQ-035 TCK_DIV=1, slave DR preloaded 38'h2A_5A5A_5A5A, cmd_ir=2'b01, cmd_data=38'h15_A5A5_A5A5 -> rsp_data=38'h2A_5A5A_5A5A, rsp_valid at acceptance+83 cycles, slave sees ir_in=01 and DR=38'h15_A5A5_A5A5 at udr.
REQ-036 TCK_DIV=3 -> tck high 3 / low 3 cycles; exactly 41 tck rising edges per transaction; 38 while vs_sdr=1.
REQ-037 rsp_ready held 0 for 20 cycles -> rsp_valid and rsp_data stable, tck stays 0, cmd_ready stays 0.
REQ-038 Two commands with cmd_valid held high -> second accepted exactly 1 cycle after return to IDLE; ir_in changes only in UIR.
REQ-039 reset pulsed at SDR bit 17 -> all outputs at reset values the same cycle, no rsp_valid; next command returns correct data.
REQ-040 All-ones then all-zeros cmd_data with tdo looped to tdi through a 38-bit model -> rsp_data equals the previous command's data.
